// File: rtl/timer_defs.sv
// Shared definitions for the timer register block: register addresses,
// TCR/TSR bit positions and the bus-responder state encoding.
package timer_defs;

    localparam logic [1:0] ADDR_TDR  = 2'd0;
    localparam logic [1:0] ADDR_TCR  = 2'd1;
    localparam logic [1:0] ADDR_TSR  = 2'd2;
    localparam logic [1:0] ADDR_TCNT = 2'd3;

    localparam int TCR_LOAD   = 7;
    localparam int TCR_DN     = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_slave_fsm.sv
// APB transfer sequencer: counts wait states, captures the request at the
// start of the access phase and flags the single completion (DONE) cycle.
module apb_slave_fsm
    import timer_defs::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int WAIT_ST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [ADDR_W-1:0] i_paddr,
    input  logic [DATA_W-1:0] i_pwdata,
    output logic              o_done,
    output logic              o_enter_done,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata
);

    localparam logic [1:0] WAIT_INIT = 2'(WAIT_ST);

    apb_state_t        r_state, w_next;
    logic [1:0]        r_cnt, w_cnt_next;
    logic              w_access, w_capture;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;

    assign w_access = i_psel & i_penable;

    // With zero wait states the access goes straight to DONE so pready
    // follows penable by exactly one cycle.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_capture  = 1'b1;
                    w_cnt_next = WAIT_INIT;
                    w_next     = (WAIT_INIT == 2'd0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_access) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 2'd1;
                    if (r_cnt <= 2'd1) w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr  <= i_paddr;
                r_wdata <= i_pwdata;
                r_write <= i_pwrite;
            end
        end
    end

    // In IDLE the live bus request is forwarded so the read mux is valid on
    // the same edge that captures it (zero-wait-state case).
    assign o_done       = (r_state == ST_DONE);
    assign o_enter_done = (w_next == ST_DONE);
    assign o_addr       = (r_state == ST_IDLE) ? i_paddr  : r_addr;
    assign o_write      = (r_state == ST_IDLE) ? i_pwrite : r_write;
    assign o_wdata      = r_wdata;

endmodule

// File: rtl/timer_apb_regs.sv
// Timer register block: TDR/TCR/TSR behind an APB responder, driving the
// counter core controls and latching its overflow/underflow events.
module timer_apb_regs
    import timer_defs::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int WAIT_ST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tdr_o,
    output logic              load_o,
    output logic              en_o,
    output logic              dn_o,
    output logic [1:0]        cks_o,
    input  logic [DATA_W-1:0] cnt_i,
    input  logic              ovf_set_i,
    input  logic              udf_set_i
);

    logic              w_done, w_enter_done, w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    apb_slave_fsm #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WAIT_ST(WAIT_ST)
    ) u_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_psel      (psel),
        .i_penable   (penable),
        .i_pwrite    (pwrite),
        .i_paddr     (paddr),
        .i_pwdata    (pwdata),
        .o_done      (w_done),
        .o_enter_done(w_enter_done),
        .o_write     (w_write),
        .o_addr      (w_addr),
        .o_wdata     (w_wdata)
    );

    logic [DATA_W-1:0] r_tdr, r_rdata, w_rmux;
    logic              r_dn, r_en, r_ovf, r_udf, r_load, r_err;
    logic [1:0]        r_cks;
    logic              w_upper_bad, w_err, w_commit;
    logic              w_wr_tdr, w_wr_tcr, w_wr_tsr;

    assign w_upper_bad = |w_addr[ADDR_W-1:2];
    assign w_err       = w_upper_bad | (w_write & (w_addr[1:0] == ADDR_TCNT));

    always_comb begin
        w_rmux = '0;
        if (!w_err) begin
            case (w_addr[1:0])
                ADDR_TDR: w_rmux = r_tdr;
                ADDR_TCR: begin
                    w_rmux[TCR_DN]                = r_dn;
                    w_rmux[TCR_EN]                = r_en;
                    w_rmux[TCR_CKS_HI:TCR_CKS_LO] = r_cks;
                end
                ADDR_TSR: begin
                    w_rmux[TSR_OVF] = r_ovf;
                    w_rmux[TSR_UDF] = r_udf;
                end
                ADDR_TCNT: w_rmux = cnt_i;
                default:   w_rmux = '0;
            endcase
        end
    end

    // Writes land on the edge that closes the DONE cycle; errored writes drop.
    assign w_commit = w_done & w_write & ~r_err;
    assign w_wr_tdr = w_commit & (w_addr[1:0] == ADDR_TDR);
    assign w_wr_tcr = w_commit & (w_addr[1:0] == ADDR_TCR);
    assign w_wr_tsr = w_commit & (w_addr[1:0] == ADDR_TSR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tdr   <= '0;
            r_dn    <= 1'b0;
            r_en    <= 1'b0;
            r_cks   <= 2'd0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            if (w_enter_done) begin
                r_rdata <= w_rmux;
                r_err   <= w_err;
            end
            if (w_wr_tdr) r_tdr <= w_wdata;
            if (w_wr_tcr) begin
                r_dn  <= w_wdata[TCR_DN];
                r_en  <= w_wdata[TCR_EN];
                r_cks <= w_wdata[TCR_CKS_HI:TCR_CKS_LO];
            end
            r_load <= w_wr_tcr & w_wdata[TCR_LOAD];
            // A hardware event in the same cycle as a W1C wins.
            r_ovf <= ovf_set_i | (r_ovf & ~(w_wr_tsr & w_wdata[TSR_OVF]));
            r_udf <= udf_set_i | (r_udf & ~(w_wr_tsr & w_wdata[TSR_UDF]));
        end
    end

    assign pready  = w_done;
    assign prdata  = w_done ? r_rdata : '0;
    assign pslverr = w_done & r_err;
    assign tdr_o   = r_tdr;
    assign load_o  = r_load;
    assign en_o    = r_en;
    assign dn_o    = r_dn;
    assign cks_o   = r_cks;

endmodule
